// File: rtl/booth_r4_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : booth_r4_seq_multiplier
// Description : Iterative radix-4 Booth multiplier. Consumes one recoded
//               multiplier digit per clock and accumulates the partial
//               products sequentially. Operands and results use valid/ready
//               handshakes, and the block supports abort.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_r4_seq_multiplier #(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 abort,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_product,
    output logic                 busy
);

    // In unsigned mode, one extra digit absorbs the zero-extended top bits.
    localparam int NDIG = SIGNED ? (WIDTH / 2) : (WIDTH / 2 + 1);
    localparam int CW   = $clog2(NDIG + 1);
    localparam int AW   = 2 * WIDTH + 2;   // accumulator / shifted multiplicand
    localparam int BW   = WIDTH + 3;       // {2 ext bits, b, implicit b[-1]}
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       mcand_q, mcand_d;   // multiplicand, pre-shifted by 2i
    logic [AW-1:0]       acc_q,   acc_d;
    logic [BW-1:0]       mplier_q, mplier_d; // multiplier, shifted so digit i sits in [2:0]
    logic [CW-1:0]       cnt_q,   cnt_d;
    logic [2*WIDTH-1:0]  prod_q,  prod_d;

    logic                sel1, sel2, neg;
    logic [AW-1:0]       pp_mag, pp, acc_sum;
    logic                a_ext, b_ext;

    assign a_ext = SIGNED ? in_a[WIDTH-1] : 1'b0;
    assign b_ext = SIGNED ? in_b[WIDTH-1] : 1'b0;

    // Booth recode the current triplet into the partial product for this digit.
    always_comb begin
        sel1 = 1'b0;
        sel2 = 1'b0;
        neg  = 1'b0;
        case (mplier_q[2:0])
            3'b001, 3'b010: sel1 = 1'b1;
            3'b011:         sel2 = 1'b1;
            3'b100:         begin sel2 = 1'b1; neg = 1'b1; end
            3'b101, 3'b110: begin sel1 = 1'b1; neg = 1'b1; end
            default:        ;
        endcase
        if (sel2) begin
            pp_mag = {mcand_q[AW-2:0], 1'b0};
        end else if (sel1) begin
            pp_mag = mcand_q;
        end else begin
            pp_mag = '0;
        end
        pp      = neg ? (~pp_mag + AW'(1)) : pp_mag;
        acc_sum = acc_q + pp;
    end

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                // Abort on the same edge blocks acceptance.
                if (in_valid && !abort) begin
                    mcand_d  = {{(AW - WIDTH){a_ext}}, in_a};
                    mplier_d = {{2{b_ext}}, in_b, 1'b0};
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                busy = 1'b1;
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d    = acc_sum;
                    mcand_d  = {mcand_q[AW-3:0], 2'b00};
                    mplier_d = {2'b00, mplier_q[BW-1:2]};
                    cnt_d    = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        prod_d  = acc_sum[2*WIDTH-1:0];
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (abort || out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
        end
    end

    assign out_product = prod_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_r4_seq_multiplier.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_booth_r4_seq_multiplier
// Description : Self-checking bench for booth_r4_seq_multiplier covering
//               W=8/16 in signed and unsigned modes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_r4_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        abort;
    logic        out_ready;
    logic [3:0]  iv;
    logic [3:0]  rdy;
    logic [3:0]  ov;
    logic [3:0]  bsy;
    logic [7:0]  a8, b8;
    logic [15:0] a16, b16;
    logic [15:0] p_s8, p_u8;
    logic [31:0] p_s16, p_u16;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    booth_r4_seq_multiplier #(.WIDTH(8), .SIGNED(1'b1)) u_s8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(rdy[0]),
        .in_a(a8), .in_b(b8), .abort(abort), .out_valid(ov[0]),
        .out_ready(out_ready), .out_product(p_s8), .busy(bsy[0]));

    booth_r4_seq_multiplier #(.WIDTH(8), .SIGNED(1'b0)) u_u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(rdy[1]),
        .in_a(a8), .in_b(b8), .abort(abort), .out_valid(ov[1]),
        .out_ready(out_ready), .out_product(p_u8), .busy(bsy[1]));

    booth_r4_seq_multiplier #(.WIDTH(16), .SIGNED(1'b1)) u_s16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(rdy[2]),
        .in_a(a16), .in_b(b16), .abort(abort), .out_valid(ov[2]),
        .out_ready(out_ready), .out_product(p_s16), .busy(bsy[2]));

    booth_r4_seq_multiplier #(.WIDTH(16), .SIGNED(1'b0)) u_u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(rdy[3]),
        .in_a(a16), .in_b(b16), .abort(abort), .out_valid(ov[3]),
        .out_ready(out_ready), .out_product(p_u16), .busy(bsy[3]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] prod_of(input int d);
        case (d)
            0:       prod_of = {16'h0, p_s8};
            1:       prod_of = {16'h0, p_u8};
            2:       prod_of = p_s16;
            default: prod_of = p_u16;
        endcase
    endfunction

    task automatic wait_ready(input int d);
        int t = 0;
        while (!rdy[d] && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        check("in_ready_wait", {31'h0, rdy[d]}, 32'h1);
    endtask

    // Issue one operation and wait for out_valid; operands are disturbed
    // after acceptance to show the latched copy is used.
    task automatic do_op(input int d, input logic [15:0] a, input logic [15:0] b,
                         output logic [31:0] p, output int lat);
        wait_ready(d);
        if (d < 2) begin a8 = a[7:0]; b8 = b[7:0]; end
        else       begin a16 = a;     b16 = b;     end
        iv[d] = 1'b1;
        @(posedge clk); #1;
        iv[d] = 1'b0;
        a8  = ~a8;  b8  = b8 + 8'd3;
        a16 = ~a16; b16 = b16 + 16'd7;
        lat = 0;
        while (!ov[d] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        p = prod_of(d);
    endtask

    initial begin
        logic [31:0] p;
        int          lat;
        logic [15:0] ra, rb;
        longint      e;
        logic [63:0] ev;
        logic        seen;
        int          ndig [4];

        ndig[0] = 4; ndig[1] = 5; ndig[2] = 8; ndig[3] = 9;
        rst_n = 1'b0; abort = 1'b0; out_ready = 1'b1; iv = 4'h0;
        a8 = '0; b8 = '0; a16 = '0; b16 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'h0, rdy[0]}, 32'h1);
        check("rst_out_valid", {31'h0, ov[0]}, 32'h0);
        check("rst_busy", {31'h0, bsy[0]}, 32'h0);
        check("rst_product", {16'h0, p_s8}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed signed W=8
        do_op(0, 16'h08, 16'h03, p, lat);
        check("s8_lat", lat, 4);
        check("s8_08x03", p, 32'h0018);
        do_op(0, 16'h80, 16'h80, p, lat);
        check("s8_80x80", p, 32'h4000);
        do_op(0, 16'h7F, 16'hFF, p, lat);
        check("s8_7Fx FF", p, 32'hFF81);
        do_op(0, 16'h00, 16'hAB, p, lat);
        check("s8_00xAB", p, 32'h0000);

        // Directed unsigned W=8
        do_op(1, 16'hFF, 16'hFF, p, lat);
        check("u8_lat", lat, 5);
        check("u8_FFxFF", p, 32'hFE01);
        do_op(1, 16'h80, 16'h02, p, lat);
        check("u8_80x02", p, 32'h0100);

        // Backpressure: hold out_ready low with in_valid asserted
        out_ready = 1'b0;
        do_op(0, 16'h05, 16'h07, p, lat);
        check("bp_first", p, 32'h0023);
        iv[0] = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("bp_out_valid", {31'h0, ov[0]}, 32'h1);
            check("bp_product", {16'h0, p_s8}, 32'h0023);
            check("bp_in_ready", {31'h0, rdy[0]}, 32'h0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_valid_drop", {31'h0, ov[0]}, 32'h0);
        check("bp_ready_rise", {31'h0, rdy[0]}, 32'h1);
        check("bp_not_early", {31'h0, bsy[0]}, 32'h0);
        iv[0] = 1'b0;
        @(posedge clk); #1;
        check("bp_idle", {31'h0, bsy[0]}, 32'h0);

        // Abort at the second BUSY cycle
        wait_ready(0);
        a8 = 8'h11; b8 = 8'h22; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_in_ready", {31'h0, rdy[0]}, 32'h1);
        check("abort_busy", {31'h0, bsy[0]}, 32'h0);
        seen = ov[0];
        repeat (6) begin
            @(posedge clk); #1;
            seen = seen | ov[0];
        end
        check("abort_no_valid", {31'h0, seen}, 32'h0);
        do_op(0, 16'h03, 16'h05, p, lat);
        check("abort_next_op", p, 32'h000F);
        repeat (3) @(posedge clk);
        #1;
        check("idle_hold_product", {16'h0, p_s8}, 32'h000F);

        // Abort in IDLE beats acceptance
        abort = 1'b1; iv[0] = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; iv[0] = 1'b0;
        check("abort_idle_noaccept", {31'h0, bsy[0]}, 32'h0);

        // Asynchronous reset mid-BUSY
        wait_ready(0);
        a8 = 8'h09; b8 = 8'h07; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", {31'h0, rdy[0]}, 32'h1);
        check("arst_busy", {31'h0, bsy[0]}, 32'h0);
        check("arst_out_valid", {31'h0, ov[0]}, 32'h0);
        check("arst_product", {16'h0, p_s8}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            seen = seen | ov[0];
        end
        check("arst_no_result", {31'h0, seen}, 32'h0);

        // Random vectors against a*b
        for (int d = 0; d < 4; d++) begin
            for (int k = 0; k < 500; k++) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                if (d < 2) begin ra[15:8] = 8'h0; rb[15:8] = 8'h0; end
                case (d)
                    0:       e = longint'($signed(ra[7:0])) * longint'($signed(rb[7:0]));
                    1:       e = longint'(ra[7:0]) * longint'(rb[7:0]);
                    2:       e = longint'($signed(ra)) * longint'($signed(rb));
                    default: e = longint'(ra) * longint'(rb);
                endcase
                ev = 64'(e);
                do_op(d, ra, rb, p, lat);
                check("rand_lat", lat, ndig[d]);
                if (d < 2) check("rand_prod8", p, {16'h0, ev[15:0]});
                else       check("rand_prod16", p, ev[31:0]);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
